dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the CPU core (port A, "cpu_") and an external loader/debug master (port B, "ext_").
- Performs round-robin arbitration and base-address translation: byte address minus data-segment base, divided by 4, gives the word index.
- Sequences each access as a fixed two-state transaction and returns registered read data with a one-cycle ack pulse.
- Sits between the core/loader and the DMEM instance in the top-level dataflow.

---
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data-memory port (CPU = A, loader/debug = B).
// Latency: grant edge N, DMEM strobed in ACCESS, one-cycle ack pulse in RESP; one access per 3 cycles.
// Backpressure: a requester holds req until it sees ack; the loser of a tie waits for the next IDLE.
// Optional range check enabled by defining DMEM_RANGE_CHECK_EN (default build: err outputs tied 0).
module dmem_arbiter #(
  parameter logic [31:0] DM_BASE = 32'h10010000,
  parameter int          ADDR_W  = 11,
  parameter int          DEPTH   = 2048
) (
  input  logic              clk,
  input  logic              reset,
  // port A: CPU core
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_sel,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  // port B: external loader / debug master
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [1:0]        ext_sel,
  input  logic [31:0]       ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_ack,
  output logic [31:0]       ext_rdata,
  output logic              ext_err,
  // DMEM side
  output logic              dm_w,
  output logic              dm_r,
  output logic [1:0]        dm_sel,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic        last_ext;  // 1 = EXT was granted most recently
  logic        gnt_ext;   // port owning the in-flight transaction
  logic        we_q;      // in-flight transaction is a write

  logic        pick_ext;
  logic        any_req;
  logic        m_we;
  logic [1:0]  m_sel;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;

  // Byte address to word index; subtraction wraps modulo 2^32, low 2 bits dropped.
  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
    return ADDR_W'((a - DM_BASE) >> 2);
  endfunction

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q;

  // Flags addresses below the segment base or beyond the last valid word.
  function automatic logic out_of_range(input logic [31:0] a);
    return (a < DM_BASE) || (((a - DM_BASE) >> 2) >= 32'(DEPTH));
  endfunction
`endif

  // Round-robin choice and mux of the winning port's request fields.
  always_comb begin
    any_req  = cpu_req | ext_req;
    pick_ext = ext_req & (~cpu_req | ~last_ext);
    m_we     = pick_ext ? ext_we    : cpu_we;
    m_sel    = pick_ext ? ext_sel   : cpu_sel;
    m_addr   = pick_ext ? ext_addr  : cpu_addr;
    m_wdata  = pick_ext ? ext_wdata : cpu_wdata;
  end

  // Transaction FSM; every output is a register so reset clears them asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_ext  <= 1'b1;
      gnt_ext   <= 1'b0;
      we_q      <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 32'h0;
      ext_ack   <= 1'b0;
      ext_rdata <= 32'h0;
      dm_w      <= 1'b0;
      dm_r      <= 1'b0;
      dm_sel    <= 2'b00;
      dm_addr   <= '0;
      dm_wdata  <= 32'h0;
      busy      <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      err_q     <= 1'b0;
      cpu_err   <= 1'b0;
      ext_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            // The dm_* registers double as the latched transaction fields.
            gnt_ext  <= pick_ext;
            last_ext <= pick_ext;
            we_q     <= m_we;
            dm_sel   <= m_sel;
            dm_addr  <= word_idx(m_addr);
            dm_wdata <= m_wdata;
            busy     <= 1'b1;
            state    <= ACCESS;
`ifdef DMEM_RANGE_CHECK_EN
            err_q    <= out_of_range(m_addr);
            dm_w     <= m_we  & ~out_of_range(m_addr);
            dm_r     <= ~m_we & ~out_of_range(m_addr);
`else
            dm_w     <= m_we;
            dm_r     <= ~m_we;
`endif
          end
        end
        ACCESS: begin
          dm_w  <= 1'b0;
          dm_r  <= 1'b0;
          state <= RESP;
          // Read data is captured here; writes and flagged accesses return 0.
          if (gnt_ext) begin
            ext_ack <= 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
            ext_rdata <= (we_q | err_q) ? 32'h0 : dm_rdata;
            ext_err   <= err_q;
`else
            ext_rdata <= we_q ? 32'h0 : dm_rdata;
`endif
          end else begin
            cpu_ack <= 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
            cpu_rdata <= (we_q | err_q) ? 32'h0 : dm_rdata;
            cpu_err   <= err_q;
`else
            cpu_rdata <= we_q ? 32'h0 : dm_rdata;
`endif
          end
        end
        RESP: begin
          cpu_ack   <= 1'b0;
          ext_ack   <= 1'b0;
          cpu_rdata <= 32'h0;
          ext_rdata <= 32'h0;
          busy      <= 1'b0;
          state     <= IDLE;
`ifdef DMEM_RANGE_CHECK_EN
          cpu_err   <= 1'b0;
          ext_err   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef DMEM_RANGE_CHECK_EN
  assign cpu_err = 1'b0;
  assign ext_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single-port transactions plus
// hand-written sequences for arbitration, late requests and mid-access reset.
// Works with or without DMEM_RANGE_CHECK_EN defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [1:0]  cpu_sel, ext_sel;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_ack, cpu_err, ext_ack, ext_err;
  logic [31:0] cpu_rdata, ext_rdata;
  logic        dm_w, dm_r, busy;
  logic [1:0]  dm_sel;
  logic [10:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;

  int checks = 0;
  int errors = 0;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .ext_req(ext_req), .ext_we(ext_we), .ext_sel(ext_sel), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata), .ext_err(ext_err),
    .dm_w(dm_w), .dm_r(dm_r), .dm_sel(dm_sel), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Read and write strobes must never overlap.
  always @(negedge clk) chk("strobe_excl", {31'b0, dm_w & dm_r}, 32'h0);

  typedef struct {
    bit          ext;
    bit          we;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;       // value DMEM returns
    logic [10:0] idx;      // expected dm_addr
    bit          e_w;
    bit          e_r;
    logic [31:0] e_rdata;
    bit          e_err;
  } vec_t;

  vec_t vecs[8];

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_sel = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_sel = 0; ext_addr = 0; ext_wdata = 0;
    dm_rdata = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 0;
    #2;
    chk("rst_ctl", {25'b0, cpu_ack, ext_ack, cpu_err, ext_err, dm_w, dm_r, busy}, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_ext_rdata", ext_rdata, 32'h0);
    chk("rst_dm", {19'b0, dm_sel, dm_addr}, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic do_txn(input vec_t v, input int i);
    string s;
    s = $sformatf("v%0d", i);
    @(negedge clk);
    dm_rdata = v.rd;
    if (v.ext) begin
      ext_req = 1; ext_we = v.we; ext_sel = v.sel; ext_addr = v.addr; ext_wdata = v.wdata;
    end else begin
      cpu_req = 1; cpu_we = v.we; cpu_sel = v.sel; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    @(posedge clk); #1;  // ACCESS
    chk({s, "_acc_idx"}, {21'b0, dm_addr}, {21'b0, v.idx});
    chk({s, "_acc_strobe"}, {30'b0, dm_w, dm_r}, {30'b0, v.e_w, v.e_r});
    chk({s, "_acc_sel"}, {30'b0, dm_sel}, {30'b0, v.sel});
    chk({s, "_acc_wdata"}, dm_wdata, v.wdata);
    chk({s, "_acc_ack_busy"}, {29'b0, cpu_ack, ext_ack, busy}, 32'h1);
    @(posedge clk); #1;  // RESP
    chk({s, "_rsp_ack_busy"}, {29'b0, cpu_ack, ext_ack, busy},
        {29'b0, !v.ext, v.ext, 1'b1});
    chk({s, "_rsp_rdata"}, v.ext ? ext_rdata : cpu_rdata, v.e_rdata);
    chk({s, "_rsp_err"}, {30'b0, cpu_err, ext_err}, {30'b0, v.e_err & !v.ext, v.e_err & v.ext});
    chk({s, "_rsp_strobe"}, {30'b0, dm_w, dm_r}, 32'h0);
    @(negedge clk);
    cpu_req = 0; ext_req = 0;
    @(posedge clk); #1;  // back in IDLE
    chk({s, "_idle"}, {29'b0, cpu_ack, ext_ack, busy}, 32'h0);
  endtask

  initial begin
    reset = 1;
    idle_inputs();

    //          ext we sel    addr          wdata         rd            idx     w  r  rdata         err
    vecs[0] = '{0, 1, 2'b10, 32'h10010008, 32'hDEADBEEF, 32'h00000000, 11'd2, 1, 0, 32'h00000000, 0};
    vecs[1] = '{0, 0, 2'b10, 32'h10010008, 32'h00000000, 32'hDEADBEEF, 11'd2, 0, 1, 32'hDEADBEEF, 0};
    vecs[2] = '{1, 1, 2'b01, 32'h10010FFF, 32'h12345678, 32'hA5A5A5A5, 11'h3FF, 1, 0, 32'h00000000, 0};
    vecs[3] = '{1, 0, 2'b00, 32'h10011FFC, 32'h00000000, 32'hCAFEF00D, 11'h7FF, 0, 1, 32'hCAFEF00D, 0};
    vecs[4] = '{0, 0, 2'b11, 32'h10010003, 32'h00000000, 32'h0BADF00D, 11'h000, 0, 1, 32'h0BADF00D, 0};
    // One word past the end: wraps to index 0, or is flagged with the range check.
    vecs[5] = '{0, 0, 2'b10, 32'h10012000, 32'h00000000, 32'h11112222, 11'h000,
                0, !RC, RC ? 32'h0 : 32'h11112222, RC};
    // Below the base: 0x1000 - 0x10010000 = 0xEFFF1000, >>2 -> low 11 bits 0x400.
    vecs[6] = '{1, 0, 2'b10, 32'h00001000, 32'h00000000, 32'h33334444, 11'h400,
                0, !RC, RC ? 32'h0 : 32'h33334444, RC};
    vecs[7] = '{0, 1, 2'b10, 32'h00001000, 32'h77778888, 32'h99990000, 11'h400,
                !RC, 0, 32'h0, RC};

    apply_reset();
    for (int i = 0; i < 8; i++) do_txn(vecs[i], i);

    // Both ports requesting continuously from reset: strict alternation, acks 3 cycles apart.
    begin
      int cyc;
      bit found;
      apply_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10010010;
      ext_req = 1; ext_we = 0; ext_addr = 32'h10010020;
      dm_rdata = 32'h5555AAAA;
      cyc = 0;
      for (int t = 0; t < 4; t++) begin
        found = 0;
        for (int n = 0; n < 6 && !found; n++) begin
          @(posedge clk); #1;
          cyc++;
          if (cpu_ack | ext_ack) found = 1;
        end
        chk($sformatf("arb_found%0d", t), {31'b0, found}, 32'h1);
        chk($sformatf("arb_who%0d", t), {30'b0, cpu_ack, ext_ack},
            (t % 2 == 0) ? 32'h2 : 32'h1);
        chk($sformatf("arb_cyc%0d", t), cyc, 2 + 3 * t);
      end
      @(negedge clk);
      cpu_req = 0; ext_req = 0;
      @(posedge clk); #1;
      chk("arb_idle", {31'b0, busy}, 32'h0);
    end

    // EXT alone, CPU arrives during EXT's ACCESS: EXT finishes, CPU takes the next IDLE.
    @(negedge clk);
    ext_req = 1; ext_we = 1; ext_addr = 32'h10010030; ext_wdata = 32'hFEEDFACE;
    @(posedge clk); #1;
    chk("late_ext_acc", {19'b0, dm_w, dm_r, dm_addr}, {19'b0, 2'b10, 11'd12});
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10010034; dm_rdata = 32'h600DCAFE;
    @(posedge clk); #1;
    chk("late_ext_rsp", {30'b0, cpu_ack, ext_ack}, 32'h1);
    @(negedge clk);
    ext_req = 0;
    @(posedge clk); #1;
    chk("late_idle", {29'b0, cpu_ack, ext_ack, busy}, 32'h0);
    @(posedge clk); #1;
    chk("late_cpu_acc", {19'b0, dm_w, dm_r, dm_addr}, {19'b0, 2'b01, 11'd13});
    @(posedge clk); #1;
    chk("late_cpu_rsp", {30'b0, cpu_ack, ext_ack}, 32'h2);
    chk("late_cpu_rdata", cpu_rdata, 32'h600DCAFE);
    @(negedge clk);
    cpu_req = 0;
    @(posedge clk); #1;

    // Reset asserted in the middle of a write ACCESS.
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10010040; cpu_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    chk("mid_rst_pre_w", {31'b0, dm_w}, 32'h1);
    cpu_req = 0;
    #2 reset = 0;
    #1;
    chk("mid_rst_async", {29'b0, dm_w, cpu_ack, busy}, 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_noack", {30'b0, cpu_ack, ext_ack}, 32'h0);
    @(negedge clk);
    reset = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10010044;
    ext_req = 1; ext_we = 0; ext_addr = 32'h10010048;
    dm_rdata = 32'h0C0FFEE0;
    @(posedge clk); #1;
    chk("post_rst_tie", {19'b0, dm_r, 1'b0, dm_addr}, {19'b0, 2'b10, 11'd17});
    chk("post_rst_noack", {30'b0, cpu_ack, ext_ack}, 32'h0);
    @(posedge clk); #1;
    chk("post_rst_ack", {30'b0, cpu_ack, ext_ack}, 32'h2);
    chk("post_rst_rdata", cpu_rdata, 32'h0C0FFEE0);
    @(negedge clk);
    cpu_req = 0; ext_req = 0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
